// File: rtl/rvga_mem_arbiter_pkg.sv
// rtl/rvga_mem_arbiter_pkg.sv - shared types, FSM state codes and defaults for the memory arbiter
package rvga_mem_arbiter_pkg;

  typedef logic [31:0] rvga_word;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_I_BUSY = 2'd1;
  localparam logic [1:0] ST_D_BUSY = 2'd2;

  localparam bit DEFAULT_DATA_PRIORITY = 1'b1;

  // Writes return zero so a stale read value never leaks to the client.
  function automatic rvga_word capture_value(input logic is_read, input rvga_word data);
    return is_read ? data : '0;
  endfunction

endpackage

// File: rtl/rvga_arb_port.sv
// rtl/rvga_arb_port.sv - per-port done flag, read-data capture and registered response
module rvga_arb_port
  import rvga_mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     active,
  input  logic     complete,
  input  logic     was_read,
  input  rvga_word mem_rdata,
  input  logic     release_all,
  output logic     pending,
  output logic     resp,
  output rvga_word rdata
);

  logic     done;
  rvga_word cap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done <= 1'b0;
      cap  <= '0;
    end else if (release_all || !active) begin
      done <= 1'b0;
      cap  <= '0;
    end else if (complete) begin
      done <= 1'b1;
      cap  <= capture_value(was_read, mem_rdata);
    end
  end

  // The done flag doubles as the response, so resp is a plain register output.
  assign pending = active & ~done;
  assign resp    = done;
  assign rdata   = cap;

endmodule

// File: rtl/rvga_mem_arbiter.sv
// rtl/rvga_mem_arbiter.sv - arbitrates instruction and data ports onto one memory interface
module rvga_mem_arbiter
  import rvga_mem_arbiter_pkg::*;
#(
  parameter bit DATA_PRIORITY = DEFAULT_DATA_PRIORITY
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rvga_word iddr_addr,
  input  rvga_word iddr_wdata,
  input  logic     iddr_read,
  input  logic     iddr_write,
  output rvga_word iddr_rdata,
  output logic     iddr_resp,
  input  rvga_word dddr_addr,
  input  rvga_word dddr_wdata,
  input  logic     dddr_read,
  input  logic     dddr_write,
  output rvga_word dddr_rdata,
  output logic     dddr_resp,
  output rvga_word mem_addr,
  output rvga_word mem_wdata,
  output logic     mem_read,
  output logic     mem_write,
  input  rvga_word mem_rdata,
  input  logic     mem_resp
);

  logic [1:0] state;
  logic       i_active, d_active;
  logic       i_pending, d_pending;
  logic       grant_i, grant_d;
  logic       release_all;

  assign i_active = iddr_read | iddr_write;
  assign d_active = dddr_read | dddr_write;

  assign grant_d = d_pending & (DATA_PRIORITY | ~i_pending);
  assign grant_i = i_pending & ~grant_d;

  // Both clients are released together once every requesting port holds its response.
  assign release_all = (i_active | d_active)
                     & (~i_active | iddr_resp)
                     & (~d_active | dddr_resp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state     <= ST_D_BUSY;
            mem_addr  <= dddr_addr;
            mem_wdata <= dddr_wdata;
            mem_write <= dddr_write;
            mem_read  <= dddr_read & ~dddr_write;
          end else if (grant_i) begin
            state     <= ST_I_BUSY;
            mem_addr  <= iddr_addr;
            mem_wdata <= iddr_wdata;
            mem_write <= iddr_write;
            mem_read  <= iddr_read & ~iddr_write;
          end
        end
        ST_I_BUSY, ST_D_BUSY: begin
          if (mem_resp) begin
            state     <= ST_IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rvga_arb_port u_iport (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (i_active),
    .complete    ((state == ST_I_BUSY) && mem_resp),
    .was_read    (mem_read),
    .mem_rdata   (mem_rdata),
    .release_all (release_all),
    .pending     (i_pending),
    .resp        (iddr_resp),
    .rdata       (iddr_rdata)
  );

  rvga_arb_port u_dport (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (d_active),
    .complete    ((state == ST_D_BUSY) && mem_resp),
    .was_read    (mem_read),
    .mem_rdata   (mem_rdata),
    .release_all (release_all),
    .pending     (d_pending),
    .resp        (dddr_resp),
    .rdata       (dddr_rdata)
  );

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// tb/tb_rvga_mem_arbiter.sv - directed self-checking bench for rvga_mem_arbiter (both priorities)
module tb_rvga_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iddr_addr, iddr_wdata, dddr_addr, dddr_wdata, mem_rdata;
  logic        iddr_read, iddr_write, dddr_read, dddr_write, mem_resp;

  logic [31:0] p1_iddr_rdata, p1_dddr_rdata, p1_mem_addr, p1_mem_wdata;
  logic        p1_iddr_resp, p1_dddr_resp, p1_mem_read, p1_mem_write;
  logic [31:0] p0_iddr_rdata, p0_dddr_rdata, p0_mem_addr, p0_mem_wdata;
  logic        p0_iddr_resp, p0_dddr_resp, p0_mem_read, p0_mem_write;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rvga_mem_arbiter #(.DATA_PRIORITY(1'b1)) dut_p1 (
    .clk(clk), .rst_n(rst_n),
    .iddr_addr(iddr_addr), .iddr_wdata(iddr_wdata), .iddr_read(iddr_read), .iddr_write(iddr_write),
    .iddr_rdata(p1_iddr_rdata), .iddr_resp(p1_iddr_resp),
    .dddr_addr(dddr_addr), .dddr_wdata(dddr_wdata), .dddr_read(dddr_read), .dddr_write(dddr_write),
    .dddr_rdata(p1_dddr_rdata), .dddr_resp(p1_dddr_resp),
    .mem_addr(p1_mem_addr), .mem_wdata(p1_mem_wdata), .mem_read(p1_mem_read), .mem_write(p1_mem_write),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  rvga_mem_arbiter #(.DATA_PRIORITY(1'b0)) dut_p0 (
    .clk(clk), .rst_n(rst_n),
    .iddr_addr(iddr_addr), .iddr_wdata(iddr_wdata), .iddr_read(iddr_read), .iddr_write(iddr_write),
    .iddr_rdata(p0_iddr_rdata), .iddr_resp(p0_iddr_resp),
    .dddr_addr(dddr_addr), .dddr_wdata(dddr_wdata), .dddr_read(dddr_read), .dddr_write(dddr_write),
    .dddr_rdata(p0_dddr_rdata), .dddr_resp(p0_dddr_resp),
    .mem_addr(p0_mem_addr), .mem_wdata(p0_mem_wdata), .mem_read(p0_mem_read), .mem_write(p0_mem_write),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iddr_addr = '0; iddr_wdata = '0; iddr_read = 1'b0; iddr_write = 1'b0;
    dddr_addr = '0; dddr_wdata = '0; dddr_read = 1'b0; dddr_write = 1'b0;
    mem_rdata = '0; mem_resp = 1'b0;
    tick(); tick();
    total++; if (p1_mem_read !== 1'b0 || p1_mem_write !== 1'b0) $display("FAIL reset_mem_op got %b%b exp 00", p1_mem_read, p1_mem_write); else passed++;
    total++; if (p1_mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h exp 0", p1_mem_addr); else passed++;
    total++; if (p1_iddr_resp !== 1'b0 || p1_dddr_resp !== 1'b0) $display("FAIL reset_resp got %b%b exp 00", p1_iddr_resp, p1_dddr_resp); else passed++;
    total++; if (p1_iddr_rdata !== 32'h0 || p0_dddr_rdata !== 32'h0) $display("FAIL reset_rdata got %h/%h exp 0", p1_iddr_rdata, p0_dddr_rdata); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_instr_read();
    iddr_read = 1'b1; iddr_addr = 32'h100;
    tick();
    total++; if (p1_mem_read !== 1'b1 || p1_mem_addr !== 32'h100) $display("FAIL ird_c1 got rd=%b addr=%h exp rd=1 addr=100", p1_mem_read, p1_mem_addr); else passed++;
    total++; if (p1_mem_write !== 1'b0) $display("FAIL ird_c1_write got %b exp 0", p1_mem_write); else passed++;
    tick();
    total++; if (p1_mem_read !== 1'b1) $display("FAIL ird_c2 mem_read got %b exp 1", p1_mem_read); else passed++;
    tick();
    total++; if (p1_mem_read !== 1'b1 || p1_iddr_resp !== 1'b0) $display("FAIL ird_c3 got rd=%b resp=%b exp rd=1 resp=0", p1_mem_read, p1_iddr_resp); else passed++;
    mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_resp = 1'b0; mem_rdata = 32'h0;
    total++; if (p1_iddr_resp !== 1'b1 || p1_iddr_rdata !== 32'hDEADBEEF) $display("FAIL ird_c4 got resp=%b rdata=%h exp resp=1 rdata=deadbeef", p1_iddr_resp, p1_iddr_rdata); else passed++;
    total++; if (p1_mem_read !== 1'b0) $display("FAIL ird_c4_drop mem_read got %b exp 0", p1_mem_read); else passed++;
    total++; if (p0_iddr_rdata !== 32'hDEADBEEF) $display("FAIL ird_c4_p0 rdata got %h exp deadbeef", p0_iddr_rdata); else passed++;
    iddr_read = 1'b0;
    tick();
    total++; if (p1_iddr_resp !== 1'b0 || p1_iddr_rdata !== 32'h0) $display("FAIL ird_c5 got resp=%b rdata=%h exp 0/0", p1_iddr_resp, p1_iddr_rdata); else passed++;
    total++; if (p1_mem_read !== 1'b0) $display("FAIL ird_c5_idle mem_read got %b exp 0", p1_mem_read); else passed++;
    tick();
  endtask

  task automatic test_simultaneous();
    iddr_read = 1'b1; iddr_addr = 32'h200;
    dddr_write = 1'b1; dddr_addr = 32'h300; dddr_wdata = 32'h55;
    tick();
    total++; if (p1_mem_write !== 1'b1 || p1_mem_addr !== 32'h300 || p1_mem_wdata !== 32'h55) $display("FAIL sim_p1_first got wr=%b addr=%h wdata=%h exp 1/300/55", p1_mem_write, p1_mem_addr, p1_mem_wdata); else passed++;
    total++; if (p0_mem_read !== 1'b1 || p0_mem_addr !== 32'h200) $display("FAIL sim_p0_first got rd=%b addr=%h exp 1/200", p0_mem_read, p0_mem_addr); else passed++;
    mem_resp = 1'b1; mem_rdata = 32'hCAFE0001;
    tick();
    mem_resp = 1'b0; mem_rdata = 32'h0;
    total++; if (p1_dddr_resp !== 1'b1 || p1_dddr_rdata !== 32'h0) $display("FAIL sim_p1_dresp got resp=%b rdata=%h exp 1/0", p1_dddr_resp, p1_dddr_rdata); else passed++;
    total++; if (p1_mem_read !== 1'b0 || p1_mem_write !== 1'b0) $display("FAIL sim_gap got %b%b exp 00", p1_mem_read, p1_mem_write); else passed++;
    total++; if (p0_iddr_resp !== 1'b1 || p0_iddr_rdata !== 32'hCAFE0001) $display("FAIL sim_p0_iresp got resp=%b rdata=%h exp 1/cafe0001", p0_iddr_resp, p0_iddr_rdata); else passed++;
    tick();
    total++; if (p1_mem_read !== 1'b1 || p1_mem_addr !== 32'h200) $display("FAIL sim_p1_second got rd=%b addr=%h exp 1/200", p1_mem_read, p1_mem_addr); else passed++;
    total++; if (p0_mem_write !== 1'b1 || p0_mem_addr !== 32'h300) $display("FAIL sim_p0_second got wr=%b addr=%h exp 1/300", p0_mem_write, p0_mem_addr); else passed++;
    total++; if (p1_dddr_resp !== 1'b1 || p1_iddr_resp !== 1'b0) $display("FAIL sim_p1_hold got d=%b i=%b exp 1/0", p1_dddr_resp, p1_iddr_resp); else passed++;
    mem_resp = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_resp = 1'b0; mem_rdata = 32'h0;
    total++; if (p1_iddr_resp !== 1'b1 || p1_iddr_rdata !== 32'h12345678 || p1_dddr_resp !== 1'b1) $display("FAIL sim_p1_both got i=%b rdata=%h d=%b exp 1/12345678/1", p1_iddr_resp, p1_iddr_rdata, p1_dddr_resp); else passed++;
    total++; if (p0_dddr_resp !== 1'b1 || p0_dddr_rdata !== 32'h0 || p0_iddr_rdata !== 32'hCAFE0001) $display("FAIL sim_p0_both got d=%b drdata=%h irdata=%h exp 1/0/cafe0001", p0_dddr_resp, p0_dddr_rdata, p0_iddr_rdata); else passed++;
    iddr_read = 1'b0; dddr_write = 1'b0;
    tick();
    total++; if (p1_iddr_resp !== 1'b0 || p1_dddr_resp !== 1'b0 || p0_iddr_resp !== 1'b0 || p0_dddr_resp !== 1'b0) $display("FAIL sim_release got p1=%b%b p0=%b%b exp 0000", p1_iddr_resp, p1_dddr_resp, p0_iddr_resp, p0_dddr_resp); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    iddr_read = 1'b1; iddr_addr = 32'h0;
    tick();
    total++; if (p1_mem_read !== 1'b1 || p1_mem_addr !== 32'h0) $display("FAIL b2b_first got rd=%b addr=%h exp 1/0", p1_mem_read, p1_mem_addr); else passed++;
    mem_resp = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_resp = 1'b0; mem_rdata = 32'h0;
    total++; if (p1_iddr_resp !== 1'b1 || p1_iddr_rdata !== 32'h11111111) $display("FAIL b2b_resp1 got resp=%b rdata=%h exp 1/11111111", p1_iddr_resp, p1_iddr_rdata); else passed++;
    iddr_addr = 32'h4;
    tick();
    total++; if (p1_mem_read !== 1'b0 || p1_iddr_resp !== 1'b0) $display("FAIL b2b_gap got rd=%b resp=%b exp 0/0", p1_mem_read, p1_iddr_resp); else passed++;
    tick();
    total++; if (p1_mem_read !== 1'b1 || p1_mem_addr !== 32'h4) $display("FAIL b2b_second got rd=%b addr=%h exp 1/4", p1_mem_read, p1_mem_addr); else passed++;
    mem_resp = 1'b1; mem_rdata = 32'h22222222;
    tick();
    mem_resp = 1'b0; mem_rdata = 32'h0;
    total++; if (p1_iddr_resp !== 1'b1 || p1_iddr_rdata !== 32'h22222222) $display("FAIL b2b_resp2 got resp=%b rdata=%h exp 1/22222222", p1_iddr_resp, p1_iddr_rdata); else passed++;
    iddr_read = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_busy();
    dddr_write = 1'b1; dddr_addr = 32'h300; dddr_wdata = 32'h77;
    tick();
    total++; if (p1_mem_write !== 1'b1) $display("FAIL rstb_busy mem_write got %b exp 1", p1_mem_write); else passed++;
    rst_n = 1'b0; dddr_write = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (p1_mem_write !== 1'b0 || p1_mem_addr !== 32'h0 || p1_mem_wdata !== 32'h0) $display("FAIL rstb_clear got wr=%b addr=%h wdata=%h exp 0/0/0", p1_mem_write, p1_mem_addr, p1_mem_wdata); else passed++;
    tick();
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h99999999;
    tick();
    mem_resp = 1'b0; mem_rdata = 32'h0;
    total++; if (p1_dddr_resp !== 1'b0 || p1_iddr_resp !== 1'b0 || p1_dddr_rdata !== 32'h0) $display("FAIL rstb_ignored got d=%b i=%b rdata=%h exp 0/0/0", p1_dddr_resp, p1_iddr_resp, p1_dddr_rdata); else passed++;
    total++; if (p1_mem_read !== 1'b0 || p1_mem_write !== 1'b0) $display("FAIL rstb_idle got %b%b exp 00", p1_mem_read, p1_mem_write); else passed++;
    tick();
  endtask

  task automatic test_addr_stable();
    dddr_read = 1'b1; dddr_addr = 32'h300;
    tick();
    total++; if (p1_mem_read !== 1'b1 || p1_mem_addr !== 32'h300) $display("FAIL stab_issue got rd=%b addr=%h exp 1/300", p1_mem_read, p1_mem_addr); else passed++;
    dddr_addr = 32'h304;
    tick();
    total++; if (p1_mem_addr !== 32'h300) $display("FAIL stab_hold mem_addr got %h exp 300", p1_mem_addr); else passed++;
    mem_resp = 1'b1; mem_rdata = 32'hABCD0000;
    tick();
    mem_resp = 1'b0; mem_rdata = 32'h0;
    total++; if (p1_dddr_resp !== 1'b1 || p1_dddr_rdata !== 32'hABCD0000) $display("FAIL stab_resp got resp=%b rdata=%h exp 1/abcd0000", p1_dddr_resp, p1_dddr_rdata); else passed++;
    dddr_read = 1'b0;
    tick();
    total++; if (p1_dddr_resp !== 1'b0 || p1_mem_read !== 1'b0) $display("FAIL stab_done got resp=%b rd=%b exp 0/0", p1_dddr_resp, p1_mem_read); else passed++;
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_busy();
    test_addr_stable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
